// File: rtl/mips_pkg.sv
// Shared MIPS definitions: data-memory bus FSM encodings
// and the default bus timeout.
package mips_pkg;

    typedef enum logic [1:0] {
        DM_IDLE     = 2'd0,
        DM_REQ      = 2'd1,
        DM_WAIT_RSP = 2'd2,
        DM_DONE     = 2'd3
    } dm_state_t;

    localparam int DM_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/dm_bus_timer.sv
// Bus access watchdog: counts busy cycles since the last clear
// and flags expiry on the TIMEOUT_CYCLES-th busy cycle.
module dm_bus_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dm_bus_if.sv
// MEM-stage data memory to valid/ready bus bridge; stalls the pipeline
// per access. Optional watchdog enabled by DM_BUS_IF_TIMEOUT_EN.
module dm_bus_if
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DM_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_dm_r,
    input  logic        ex_mem_dm_w,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_dm_w_data,
    output logic        mem_stall,
    output logic [31:0] data_out,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    output logic        bus_err
);

    dm_state_t state, state_nxt;
    logic req, busy, start, rsp_hit, tmo;

    assign req     = ex_mem_dm_r | ex_mem_dm_w;
    assign busy    = (state == DM_REQ) || (state == DM_WAIT_RSP);
    assign start   = (state == DM_IDLE) && req;
    assign rsp_hit = (state == DM_WAIT_RSP) && bus_rsp_valid;

`ifdef DM_BUS_IF_TIMEOUT_EN
    logic expired;

    dm_bus_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .run     (busy),
        .expired (expired)
    );

    // A response arriving on the expiry cycle still completes normally.
    assign tmo = expired & ~rsp_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (tmo) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DM_IDLE:     if (req) state_nxt = DM_REQ;
            DM_REQ: begin
                if (tmo)                state_nxt = DM_DONE;
                else if (bus_req_ready) state_nxt = DM_WAIT_RSP;
            end
            DM_WAIT_RSP: if (bus_rsp_valid || tmo) state_nxt = DM_DONE;
            DM_DONE:     state_nxt = DM_IDLE;
            default:     state_nxt = DM_IDLE;
        endcase
    end

    always_comb begin
        mem_stall     = start || busy;
        bus_req_valid = (state == DM_REQ);
    end

    // Request fields are captured once so they stay stable until handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            data_out      <= '0;
        end else begin
            if (start) begin
                bus_req_we    <= ex_mem_dm_w;
                bus_req_addr  <= {ex_mem_alu_result[31:2], 2'b00};
                bus_req_wdata <= ex_mem_dm_w_data;
            end
            if (rsp_hit && !bus_req_we) begin
                data_out <= bus_rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_bus_if.sv
// Scoreboard bench for dm_bus_if: expected bus requests and load
// results are queued at issue and retired at handshake / release.
module tb_dm_bus_if;
    import mips_pkg::*;

    localparam int TMO = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_mem_dm_r, ex_mem_dm_w;
    logic [31:0] ex_mem_alu_result, ex_mem_dm_w_data;
    logic        mem_stall;
    logic [31:0] data_out;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_err;

    int vectors = 0;
    int errors  = 0;

    req_t        q_req[$];
    logic [31:0] q_dout[$];
    logic [31:0] dout_m = '0;
    logic        err_m  = 1'b0;

    always #5 clk = ~clk;

    dm_bus_if #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_mem_dm_r       (ex_mem_dm_r),
        .ex_mem_dm_w       (ex_mem_dm_w),
        .ex_mem_alu_result (ex_mem_alu_result),
        .ex_mem_dm_w_data  (ex_mem_dm_w_data),
        .mem_stall         (mem_stall),
        .data_out          (data_out),
        .bus_req_valid     (bus_req_valid),
        .bus_req_ready     (bus_req_ready),
        .bus_req_we        (bus_req_we),
        .bus_req_addr      (bus_req_addr),
        .bus_req_wdata     (bus_req_wdata),
        .bus_rsp_valid     (bus_rsp_valid),
        .bus_rsp_rdata     (bus_rsp_rdata),
        .bus_err           (bus_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_stall"}, 32'(mem_stall), 0);
        check_eq({tag, "_valid"}, 32'(bus_req_valid), 0);
        check_eq({tag, "_we"}, 32'(bus_req_we), 0);
        check_eq({tag, "_addr"}, bus_req_addr, 0);
        check_eq({tag, "_wdata"}, bus_req_wdata, 0);
        check_eq({tag, "_dout"}, data_out, 0);
        check_eq({tag, "_err"}, 32'(bus_err), 0);
    endtask

    // One memory access; rdy<=0 means the bus never accepts it.
    // spur injects a stray response while the request is pending.
    task automatic access(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int rdy,
                          input bit spur, input logic nr,
                          input logic [31:0] na);
        req_t        e;
        logic [31:0] exp_d;
        int          st, rq, exp_st, exp_rq;
        bit          seen, rsp_due, done;
        @(posedge clk); #1;
        ex_mem_dm_r       = r;
        ex_mem_dm_w       = w;
        ex_mem_alu_result = a;
        ex_mem_dm_w_data  = wd;
        q_req.push_back('{we: w, addr: {a[31:2], 2'b00}, wdata: wd});
        exp_d = (!w && rdy > 0) ? rd : dout_m;
        q_dout.push_back(exp_d);
        dout_m = exp_d;
        if (rdy <= 0) err_m = 1'b1;
        exp_rq = (rdy > 0) ? rdy : TMO;
        exp_st = (rdy > 0) ? rdy + 2 : TMO + 1;
        e = '0;
        #1;
        check_eq("idle_valid", 32'(bus_req_valid), 0);
        check_eq("idle_stall", 32'(mem_stall), 1);
        st = 1; rq = 0; seen = 0; rsp_due = 0; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk); #1;
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            if (rsp_due) begin
                check_eq("wait_valid", 32'(bus_req_valid), 0);
                bus_rsp_valid = 1'b1;
                bus_rsp_rdata = rd;
                rsp_due = 0;
            end
            if (bus_req_valid) begin
                rq++;
                if (!seen) begin
                    seen = 1;
                    check_eq("sb_req_avail", 32'(q_req.size() != 0), 1);
                    if (q_req.size() != 0) e = q_req.pop_front();
                end
                check_eq("req_we", 32'(bus_req_we), 32'(e.we));
                check_eq("req_addr", bus_req_addr, e.addr);
                check_eq("req_wdata", bus_req_wdata, e.wdata);
                if (rq == rdy) begin
                    bus_req_ready = 1'b1;
                    rsp_due = 1;
                end else if (spur && rq == 2) begin
                    bus_rsp_valid = 1'b1;
                    bus_rsp_rdata = 32'hDEAD_BEEF;
                end
            end
            #1;
            if (!mem_stall) begin
                done = 1;
                check_eq("sb_dout_avail", 32'(q_dout.size() != 0), 1);
                if (q_dout.size() != 0)
                    check_eq("data_out", data_out, q_dout.pop_front());
                check_eq("stall_cycles", st, exp_st);
                check_eq("req_cycles", rq, exp_rq);
                check_eq("bus_err", 32'(bus_err), 32'(err_m));
                ex_mem_dm_r       = nr;
                ex_mem_dm_w       = 1'b0;
                ex_mem_alu_result = na;
            end else begin
                st++;
            end
        end
        if (!done) check_eq("access_release", 0, 1);
        bus_rsp_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        ex_mem_dm_r       = 1'b0;
        ex_mem_dm_w       = 1'b0;
        ex_mem_alu_result = '0;
        ex_mem_dm_w_data  = '0;
        bus_req_ready     = 1'b0;
        bus_rsp_valid     = 1'b0;
        bus_rsp_rdata     = '0;
        #1;
        check_reset_outs("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        access(1, 0, 32'h0000_1006, 32'h0, 32'h1234_5678, 1, 0, 0, 0);
        access(0, 1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 4, 1, 0, 0);
        access(1, 1, 32'h0000_0040, 32'h55AA_33CC, 32'h0BAD_0001, 2, 0, 0, 0);
        access(1, 0, 32'h0000_0100, 32'h0, 32'hA5A5_0100, 1, 0,
               1, 32'h0000_0104);
        access(1, 0, 32'h0000_0104, 32'h0, 32'h5A5A_0104, 3, 0, 0, 0);

        // Abandon a load in WAIT_RSP; the late response must not land.
        @(posedge clk); #1;
        ex_mem_dm_r       = 1'b1;
        ex_mem_alu_result = 32'h0000_0200;
        @(posedge clk); #1;
        check_eq("abort_req_valid", 32'(bus_req_valid), 1);
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        check_eq("abort_wait_stall", 32'(mem_stall), 1);
        ex_mem_dm_r = 1'b0;
        reset       = 1'b1;
        #1;
        check_reset_outs("mid_rst");
        @(posedge clk); #1;
        reset         = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        #1;
        check_eq("late_rsp_dout", data_out, 0);
        check_eq("late_rsp_stall", 32'(mem_stall), 0);
        check_eq("late_rsp_valid", 32'(bus_req_valid), 0);
        dout_m = '0;
        err_m  = 1'b0;

        access(1, 0, 32'h0000_0300, 32'h0, 32'h0F0F_1234, 1, 0, 0, 0);

`ifdef DM_BUS_IF_TIMEOUT_EN
        access(1, 0, 32'h0000_0400, 32'h0, 32'hFFFF_0000, 0, 0, 0, 0);
        access(1, 0, 32'h0000_0404, 32'h0, 32'h7777_8888, 2, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_eq("err_clear", 32'(bus_err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        dout_m = '0;
        err_m  = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/dm_bus_if.md
DM_BUS_IF -- requirements
Module: dm_bus_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles in REQ+WAIT_RSP before abort, used only with DM_BUS_IF_TIMEOUT_EN.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ex_mem_dm_r  in  1  MEM-stage load request.
REQ-005 SHALL have port ex_mem_dm_w  in  1  MEM-stage store request.
REQ-006 SHALL have port ex_mem_alu_result  in  32  byte address.
REQ-007 SHALL have port ex_mem_dm_w_data  in  32  store data.
REQ-008 SHALL have port mem_stall  out  1  holds PC, IF_ID, ID_EX, EX_MEM and MEM_WB when high.
REQ-009 SHALL have port data_out  out  32  load data to MEM_WB.
REQ-010 SHALL have port bus_req_valid  out  1  bus request valid.
REQ-011 SHALL have port bus_req_ready  in  1  bus accepts request.
REQ-012 SHALL have port bus_req_we  out  1  1=write, 0=read.
REQ-013 SHALL have port bus_req_addr  out  32  word address.
REQ-014 SHALL have port bus_req_wdata  out  32  write data.
REQ-015 SHALL have port bus_rsp_valid  in  1  response/ack strobe.
REQ-016 SHALL have port bus_rsp_rdata  in  32  read data.
REQ-017 SHALL have port bus_err  out  1  sticky timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT_RSP, DONE.
REQ-019 IDLE: on dm_r|dm_w, SHALL register address, wdata and we (we=dm_w, so store wins if both set), then go to REQ; mem_stall SHALL be high combinationally in that same cycle.
REQ-020 REQ: bus_req_valid=1, with we/addr/wdata stable until handshake; on bus_req_ready go to WAIT_RSP.
REQ-021 WAIT_RSP: on bus_rsp_valid go to DONE; for reads, data_out <= bus_rsp_rdata; for writes, data_out is unchanged.
REQ-022 bus_rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-023 DONE: mem_stall=0 for exactly one cycle so the pipeline advances, any dm_r/dm_w in that cycle is ignored, and the next state is IDLE.
REQ-024 mem_stall SHALL be high in REQ and WAIT_RSP.
REQ-025 bus_req_addr SHALL be {addr[31:2],2'b00}.
REQ-026 Minimum access (ready in REQ, rsp on the first WAIT_RSP cycle) SHALL stall 3 cycles and release in cycle 4.
REQ-027 Back-to-back memory instructions SHALL each get a full IDLE->DONE sequence, with no lost request.
REQ-028 data_out SHALL hold the last read value between accesses.

Reset
REQ-029 Reset SHALL asynchronously force IDLE, mem_stall=0, bus_req_valid=0, bus_req_we=0, bus_req_addr=0, bus_req_wdata=0, data_out=0, bus_err=0.
REQ-030 Reset mid-transaction SHALL abandon it; late bus_rsp_valid SHALL be ignored.

Configuration
REQ-031 With DM_BUS_IF_TIMEOUT_EN defined: a counter SHALL clear on entering REQ; if it reaches TIMEOUT_CYCLES in REQ/WAIT_RSP, the FSM SHALL go to DONE, set bus_err (sticky until reset) and leave data_out unchanged.
REQ-032 Without DM_BUS_IF_TIMEOUT_EN: no counter, indefinite wait, bus_err tied 0.

Structure
REQ-033 FSM state encodings and the default timeout constant SHALL live in the shared MIPS definitions package.
REQ-034 The timeout counter SHALL be sub-module dm_bus_timer, instantiated only under DM_BUS_IF_TIMEOUT_EN.

Verification
REQ-035 Load addr 0x0000_1006, ready immediate, rsp rdata 0x1234_5678 one cycle later -> bus_req_addr 0x0000_1004, we=0, mem_stall high 3 cycles, data_out 0x1234_5678.
REQ-036 Store addr 0x20, wdata 0xCAFE_F00D, ready delayed 4 cycles -> valid/addr/wdata stable 4 cycles, we=1, data_out unchanged, stall 6 cycles.
REQ-037 dm_r=dm_w=1 at addr 0x40 -> write issued, data_out unchanged.
REQ-038 Two consecutive loads 0x100, 0x104 -> two separate handshakes, one DONE cycle between them, correct data_out each.
REQ-039 Reset asserted in WAIT_RSP, then rsp pulse -> IDLE, outputs zero, rsp ignored.
REQ-040 With macro and TIMEOUT_CYCLES=8, ready never asserted -> DONE after 8 cycles, bus_err=1 until reset.
